// File: rtl/sort_net_pipe_if.sv
// Valid/ready bundle for sort_net_pipe: input vector with mode bit, sorted output vector.
// With SORT_INDEX_EN defined it also carries dout_idx, the original lane of each output lane.
interface sort_net_pipe_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic           in_desc;
   logic [N*W-1:0] din;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] dout;
`ifdef SORT_INDEX_EN
   logic [N*4-1:0] dout_idx;

   modport slave  (input  in_valid, in_desc, din, out_ready,
                   output in_ready, out_valid, dout, dout_idx);
   modport master (output in_valid, in_desc, din, out_ready,
                   input  in_ready, out_valid, dout, dout_idx);
`else
   modport slave  (input  in_valid, in_desc, din, out_ready,
                   output in_ready, out_valid, dout);
   modport master (output in_valid, in_desc, din, out_ready,
                   input  in_ready, out_valid, dout);
`endif
endinterface

// File: rtl/sort_net_pipe.sv
// Fully pipelined bitonic sorter for N unsigned W-bit lanes, one compare-exchange layer per stage.
// Optional SORT_INDEX_EN: carries a 4-bit original-lane tag per element and drives dout_idx.
module sort_net_pipe #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   sort_net_pipe_if.slave sort_io
);
   localparam int LOG2N  = $clog2(N);
   localparam int STAGES = LOG2N * (LOG2N + 1) / 2;
`ifdef SORT_INDEX_EN
   localparam int TAGW = 4;
   localparam int EW   = W + TAGW;
   // Tags are inverted in descending mode so equal values still leave in original lane order.
   localparam logic [EW-1:0] TIE_MASK = {{W{1'b0}}, {TAGW{1'b1}}};
`else
   localparam int EW = W;
   localparam logic [EW-1:0] TIE_MASK = '0;
`endif

   function automatic logic [EW-1:0] sort_key(input logic [EW-1:0] e, input logic desc);
      return e ^ (TIE_MASK & {EW{desc}});
   endfunction

   logic [EW-1:0]     in_elem [N];
   logic [EW-1:0]     lay_in  [STAGES][N];
   logic [EW-1:0]     lay_out [STAGES][N];
   logic [EW-1:0]     data_q  [STAGES][N];
   logic [EW-1:0]     data_d  [STAGES][N];
   logic [STAGES-1:0] lay_desc;
   logic [STAGES-1:0] up_valid;
   logic [STAGES-1:0] ld;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;

   for (genvar i = 0; i < N; i++) begin : g_in
`ifdef SORT_INDEX_EN
      assign in_elem[i] = {sort_io.din[i*W +: W], TAGW'(i)};
`else
      assign in_elem[i] = sort_io.din[i*W +: W];
`endif
   end

   // The mode of the vector in the last stage is never needed, so only STAGES-1 mode bits exist.
   if (STAGES > 1) begin : g_mode
      logic [STAGES-2:0] desc_q;
      logic [STAGES-2:0] desc_d;
      for (genvar s = 0; s < STAGES - 1; s++) begin : g_bit
         assign desc_d[s] = ld[s] ? lay_desc[s] : desc_q[s];
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) desc_q <= '0;
         else        desc_q <= desc_d;
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign up_valid[s] = sort_io.in_valid;
         assign lay_desc[s] = sort_io.in_desc;
         for (genvar i = 0; i < N; i++) begin : g_lane
            assign lay_in[s][i] = in_elem[i];
         end
      end else begin : g_body
         assign up_valid[s] = valid_q[s-1];
         assign lay_desc[s] = g_mode.desc_q[s-1];
         for (genvar i = 0; i < N; i++) begin : g_lane
            assign lay_in[s][i] = data_q[s-1][i];
         end
      end
      // A stage may load whenever any stage at or below it holds a bubble (bubble collapse).
      assign ld[s]      = sort_io.out_ready | ~(&valid_q[STAGES-1:s]);
      assign valid_d[s] = ld[s] ? up_valid[s] : valid_q[s];
      for (genvar i = 0; i < N; i++) begin : g_data
         assign data_d[s][i] = ld[s] ? lay_out[s][i] : data_q[s][i];
      end
   end

   for (genvar p = 1; p <= LOG2N; p++) begin : g_merge
      for (genvar q = p; q >= 1; q--) begin : g_layer
         localparam int S = p * (p - 1) / 2 + (p - q);
         localparam int K = 1 << p;
         localparam int J = 1 << (q - 1);
         for (genvar i = 0; i < N; i++) begin : g_lane
            if ((i ^ J) > i) begin : g_cx
               localparam int L  = i ^ J;
               localparam bit UP = ((i & K) == 0);
               logic [EW-1:0] key_a;
               logic [EW-1:0] key_b;
               logic          swap;
               assign key_a = sort_key(lay_in[S][i], lay_desc[S]);
               assign key_b = sort_key(lay_in[S][L], lay_desc[S]);
               // Lane i ends up with the smaller key when the block direction matches ascending.
               assign swap  = (UP != lay_desc[S]) ? (key_a > key_b) : (key_a < key_b);
               assign lay_out[S][i] = swap ? lay_in[S][L] : lay_in[S][i];
               assign lay_out[S][L] = swap ? lay_in[S][i] : lay_in[S][L];
            end
         end
      end
   end

   // NOTE: data registers are reset as well, because the last stage is dout and must clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < N; i++) begin
               data_q[s][i] <= '0;
            end
         end
      end else begin
         // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign sort_io.in_ready  = ld[0];
   assign sort_io.out_valid = valid_q[STAGES-1];
   for (genvar i = 0; i < N; i++) begin : g_out
      assign sort_io.dout[i*W +: W] = data_q[STAGES-1][i][EW-1 -: W];
`ifdef SORT_INDEX_EN
      assign sort_io.dout_idx[i*TAGW +: TAGW] = data_q[STAGES-1][i][TAGW-1:0];
`endif
   end
endmodule

// File: tb/tb_sort_net_pipe.sv
// Directed bench for sort_net_pipe: N=4/W=8 instance plus an N=8/W=16 instance.
// Define SORT_INDEX_EN for both RTL and bench to also check dout_idx.
module tb_sort_net_pipe;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sort_net_pipe_if #(.N(4), .W(8))  bus4 ();
   sort_net_pipe_if #(.N(8), .W(16)) bus8 ();

   sort_net_pipe #(.N(4), .W(8))  dut4 (.clk(clk), .rst_n(rst_n), .sort_io(bus4));
   sort_net_pipe #(.N(8), .W(16)) dut8 (.clk(clk), .rst_n(rst_n), .sort_io(bus8));

   logic [31:0] stream_vec [10] = '{32'h12345678, 32'hFF00FF00, 32'h01020304, 32'h80808080,
                                    32'h00FF7F01, 32'hDEADBEEF, 32'h0A0B0C0D, 32'hC3A51E77,
                                    32'h00000000, 32'h9F2E6B40};
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Plain bubble sort of four bytes, lane 0 first.
   function automatic logic [31:0] ref_sort4(input logic [31:0] v, input logic desc);
      logic [7:0]  a [4];
      logic [7:0]  t;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) a[i] = v[i*8 +: 8];
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3 - i; j++) begin
            if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i];
      return r;
   endfunction

   // Sends one vector into an idle N=4 pipe and returns on the negedge it must appear.
   task automatic send4(input string tag, input logic [31:0] din, input logic desc,
                        input logic [31:0] exp);
      bus4.in_valid = 1'b1;
      bus4.din      = din;
      bus4.in_desc  = desc;
      check({tag, "_in_ready"}, bus4.in_ready, 1);
      step();
      bus4.in_valid = 1'b0;
      check({tag, "_lat1"}, bus4.out_valid, 0);
      step();
      check({tag, "_lat2"}, bus4.out_valid, 0);
      step();
      check({tag, "_valid"}, bus4.out_valid, 1);
      check({tag, "_dout"}, bus4.dout, exp);
   endtask

   task automatic send8(input string tag, input logic [127:0] din, input logic desc,
                        input logic [127:0] exp);
      bus8.in_valid = 1'b1;
      bus8.din      = din;
      bus8.in_desc  = desc;
      step();
      bus8.in_valid = 1'b0;
      repeat (4) step();
      check({tag, "_lat5"}, bus8.out_valid, 0);
      step();
      check({tag, "_valid"}, bus8.out_valid, 1);
      check({tag, "_dout"}, bus8.dout, exp);
   endtask

   initial begin
      int          sent;
      int          got;
      int          cyc;
      logic        prev_stall;
      logic [31:0] held;
      logic [31:0] exp_v;

      rst_n          = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_desc   = 1'b0;
      bus4.din       = '0;
      bus4.out_ready = 1'b1;
      bus8.in_valid  = 1'b0;
      bus8.in_desc   = 1'b0;
      bus8.din       = '0;
      bus8.out_ready = 1'b1;
      repeat (2) step();
      check("rst_out_valid", bus4.out_valid, 0);
      check("rst_dout", bus4.dout, 0);
      check("rst_out_valid8", bus8.out_valid, 0);
      check("rst_dout8", bus8.dout, 0);
`ifdef SORT_INDEX_EN
      check("rst_idx", bus4.dout_idx, 0);
`endif
      rst_n = 1'b1;

      // Basic ascending and descending sorts.
      send4("t1_asc", 32'h03F0107F, 1'b0, 32'hF07F1003);
`ifdef SORT_INDEX_EN
      check("t1_idx", bus4.dout_idx, 16'h2013);
`endif
      step();
      check("t1_drain", bus4.out_valid, 0);
      send4("t2_desc", 32'h03F0107F, 1'b1, 32'h03107FF0);
      step();
      check("t2_drain", bus4.out_valid, 0);

      // Back-to-back vectors with different modes.
      bus4.in_valid = 1'b1; bus4.in_desc = 1'b0; bus4.din = 32'h8001FF00;
      step();
      bus4.in_desc = 1'b1; bus4.din = 32'h7F7F0001;
      step();
      bus4.in_valid = 1'b0;
      step();
      check("b2b_a_valid", bus4.out_valid, 1);
      check("b2b_a_dout", bus4.dout, 32'hFF800100);
      step();
      check("b2b_b_valid", bus4.out_valid, 1);
      check("b2b_b_dout", bus4.dout, 32'h00017F7F);
      step();
      check("b2b_drain", bus4.out_valid, 0);

      // Stream of 10 vectors: one input gap at cycle 3, stall for cycles 4..8.
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
      while ((sent < 10 || got < 10) && cyc < 80) begin
         bus4.out_ready = !(cyc >= 4 && cyc < 9);
         bus4.in_valid  = (sent < 10) && (cyc != 3);
         bus4.din       = (sent < 10) ? stream_vec[sent] : 32'h0;
         bus4.in_desc   = sent[0];
         #1;
         if (prev_stall) begin
            check("stall_hold_valid", bus4.out_valid, 1);
            check("stall_hold_dout", bus4.dout, held);
         end
         if (cyc == 4) check("collapse_in_ready", bus4.in_ready, 1);
         if (cyc == 8) check("full_in_ready", bus4.in_ready, 0);
         if (bus4.out_valid && bus4.out_ready) begin
            if (exp_q.size() == 0) begin
               check("stream_extra_out", bus4.out_valid, 0);
            end else begin
               exp_v = exp_q.pop_front();
               check("stream_dout", bus4.dout, exp_v);
            end
            got++;
         end
         prev_stall = bus4.out_valid && !bus4.out_ready;
         held       = bus4.dout;
         if (bus4.in_valid && bus4.in_ready) begin
            exp_q.push_back(ref_sort4(bus4.din, bus4.in_desc));
            sent++;
         end
         step();
         cyc++;
      end
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b1;
      check("stream_sent", sent, 10);
      check("stream_got", got, 10);
      check("stream_left", exp_q.size(), 0);

      // Asynchronous reset with three vectors in flight.
      for (int i = 0; i < 3; i++) begin
         bus4.in_valid = 1'b1; bus4.in_desc = 1'b0; bus4.din = stream_vec[i];
         step();
      end
      bus4.in_valid = 1'b0;
      check("pre_rst_valid", bus4.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", bus4.out_valid, 0);
      check("rst_async_dout", bus4.dout, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("post_rst_no_stale", bus4.out_valid, 0);
         step();
      end
      send4("post_rst", 32'h55AA0099, 1'b1, 32'h005599AA);
      step();

      // Duplicate values: ascending and descending.
      send4("dup_asc", 32'h05050205, 1'b0, 32'h05050502);
`ifdef SORT_INDEX_EN
      check("dup_asc_idx", bus4.dout_idx, 16'h3201);
`endif
      step();
      send4("dup_desc", 32'h05050205, 1'b1, 32'h02050505);
`ifdef SORT_INDEX_EN
      check("dup_desc_idx", bus4.dout_idx, 16'h1320);
`endif
      step();

      // N=8, W=16 instance.
      send8("n8_asc", 128'hFFFE_0001_7FFF_0010_8000_0000_FFFF_0010, 1'b0,
            128'hFFFF_FFFE_8000_7FFF_0010_0010_0001_0000);
`ifdef SORT_INDEX_EN
      check("n8_asc_idx", bus8.dout_idx, 32'h17354062);
`endif
      step();
      send8("n8_desc", 128'hFFFE_0001_7FFF_0010_8000_0000_FFFF_0010, 1'b1,
            128'h0000_0001_0010_0010_7FFF_8000_FFFE_FFFF);
`ifdef SORT_INDEX_EN
      check("n8_desc_idx", bus8.dout_idx, 32'h26405371);
`endif
      step();
      send8("n8_equal", {8{16'h1234}}, 1'b0, {8{16'h1234}});
`ifdef SORT_INDEX_EN
      check("n8_equal_idx", bus8.dout_idx, 32'h76543210);
`endif
      step();
      send8("n8_max", {8{16'hFFFF}}, 1'b1, {8{16'hFFFF}});
`ifdef SORT_INDEX_EN
      check("n8_max_idx", bus8.dout_idx, 32'h76543210);
`endif
      step();
      check("n8_drain", bus8.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
